// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package seven_seg_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int MAX_DIGITS = 8;

   // Width of a digit index for a given digit count (never below one bit)
   function automatic int idx_w(input int num_digits);
      return (num_digits > 1) ? $clog2(num_digits) : 1;
   endfunction

   // One-hot enable for a digit index; callers truncate to their digit count
   function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
      return MAX_DIGITS'(1) << idx;
   endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Modulo-REFRESH_DIV slot counter with terminal pulse and dead-time flag.
// Latency: count updates on every enabled edge; terminal/dead are combinational from count.
// Backpressure: en=0 freezes the count and suppresses terminal.
module seven_seg_prescaler #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 16,
   parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             terminal_o,
   output logic             dead_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign terminal_o = en_i && (cnt_q == CNT_W'(REFRESH_DIV - 1));
   assign dead_o     = (cnt_q < CNT_W'(DEAD_CYCLES));
   assign count_o    = cnt_q;

   // Advance while enabled, wrap to zero at the last cycle of the slot
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = terminal_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Slot counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed 7-seg scan: holds NUM_DIGITS nibbles, walks digits with dead time; LEADING_ZERO_BLANK_EN adds leading-zero blanking.
// Latency: outputs registered one edge after the slot counter/index; a new value shows from the next frame start.
// Backpressure: value_ready drops on accept and returns the cycle after the shadow is applied at the frame wrap.
module seven_segment_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           value_valid,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
   output logic                           value_ready,
   output logic [NIBBLE_W-1:0]            nibble,
   output logic [NUM_DIGITS-1:0]          digit_en,
   output logic                           frame_tick
);

   localparam int IDX_W = idx_w(NUM_DIGITS);
   localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0] presc_count;
   logic             slot_end;
   logic             dead_time;

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      disp_q, disp_d;
   logic [VAL_W-1:0]      shadow_q, shadow_d;
   logic                  pend_q, pend_d;
   logic                  ready_q, ready_d;
   logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
   logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
   logic                  tick_q, tick_d;

   logic                  frame_wrap;
   logic                  accept;
   logic [NUM_DIGITS-1:0] slot_oh;
   logic [NUM_DIGITS-1:0] slot_lit;

   seven_seg_prescaler #(
      .REFRESH_DIV (REFRESH_DIV),
      .DEAD_CYCLES (DEAD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_prescaler (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en),
      .count_o    (presc_count),
      .terminal_o (slot_end),
      .dead_o     (dead_time)
   );

   assign frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign accept     = value_valid && ready_q;
   assign slot_oh    = NUM_DIGITS'(digit_onehot(3'(idx_q)));

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] blank;

   // Digit i>0 is dark when it and every digit above it are zero; digit 0 always lit
   always_comb begin : blank_calc
      logic upper_zero;
      blank      = '0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         upper_zero = upper_zero && (disp_q[NIBBLE_W*i +: NIBBLE_W] == NIBBLE_W'(0));
         blank[i]   = upper_zero;
      end
   end

   assign slot_lit = slot_oh & ~blank;
`else
   assign slot_lit = slot_oh;
`endif

   // Digit index, shadow handshake and frame-boundary apply
   always_comb begin
      idx_d    = idx_q;
      disp_d   = disp_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      if (slot_end) begin
         idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
      end
      // The apply uses the shadow held before this edge, so a same-edge accept cannot tear
      if (frame_wrap && pend_q) begin
         disp_d = shadow_q;
         pend_d = 1'b0;
      end
      if (accept) begin
         shadow_d = value;
         pend_d   = 1'b1;
      end
      // Ready reopens one cycle after the apply clears pend
      ready_d = !pend_q && !accept;
   end

   // Registered display outputs derived from the current index and slot phase
   always_comb begin
      nibble_d   = disp_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
      digit_en_d = (en && !dead_time) ? slot_lit : '0;
      tick_d     = frame_wrap;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         disp_q     <= '0;
         shadow_q   <= '0;
         pend_q     <= 1'b0;
         ready_q    <= 1'b1;
         nibble_q   <= '0;
         digit_en_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         shadow_q   <= shadow_d;
         pend_q     <= pend_d;
         ready_q    <= ready_d;
         nibble_q   <= nibble_d;
         digit_en_q <= digit_en_d;
         tick_q     <= tick_d;
      end
   end

   assign value_ready = ready_q;
   assign nibble      = nibble_q;
   assign digit_en    = digit_en_q;
   assign frame_tick  = tick_q;

   a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
      presc_count <= CNT_W'(REFRESH_DIV - 1));

   a_digit_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(digit_en_q));

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver (4 digits, 8-cycle slots, 2 dead cycles).
// Stimulus pushes the expected (digit_en, nibble) of each lit slot; a monitor pops on every slot light-up.
// Also tracks lit-run length, frame_tick spacing and handshake timing.
module tb_seven_segment_scan_driver;

   typedef struct packed {
      logic [3:0] en;
      logic [3:0] nib;
   } ev_t;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [3:0] LIT_ZERO = 4'b0001;
   localparam logic [3:0] LIT_00A0 = 4'b0011;
`else
   localparam logic [3:0] LIT_ZERO = 4'b1111;
   localparam logic [3:0] LIT_00A0 = 4'b1111;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        value_valid;
   logic [15:0] value;
   logic        value_ready;
   logic [3:0]  nibble;
   logic [3:0]  digit_en;
   logic        frame_tick;

   ev_t exp_q[$];
   int  checks  = 0;
   int  errors  = 0;
   int  exp_gap = 32;
   bit  len_chk = 1'b1;

   always #5 clk = ~clk;

   seven_segment_scan_driver #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .DEAD_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .value_valid (value_valid),
      .value       (value),
      .value_ready (value_ready),
      .nibble      (nibble),
      .digit_en    (digit_en),
      .frame_tick  (frame_tick)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_ev(input logic [3:0] en_v, input logic [3:0] nib_v);
      ev_t e;
      e.en  = en_v;
      e.nib = nib_v;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [15:0] v, input logic [3:0] lit);
      for (int i = 0; i < 4; i++) begin
         if (lit[i]) push_ev(4'(1 << i), v[4*i +: 4]);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!frame_tick && n < 200);
      chk("frame_tick_seen", 32'(frame_tick), 32'd1);
      chk("frame_leftover_events", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Monitor: one-hot, slot light-up scoreboard, lit-run length, tick spacing
   initial begin : monitor
      logic [3:0] prev_en;
      int         run;
      int         gap;
      ev_t        e;
      prev_en = '0;
      run     = 0;
      gap     = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            prev_en = '0;
            run     = 0;
            gap     = 0;
         end else begin
            gap++;
            checks++;
            if (!$onehot0(digit_en)) begin
               errors++;
               $display("FAIL onehot digit_en=%b required at most one bit", digit_en);
            end
            if (digit_en != 4'b0 && prev_en == 4'b0) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_slot digit_en=%b nibble=%h required no lit slot", digit_en, nibble);
               end else begin
                  e = exp_q.pop_front();
                  if (e.en !== digit_en || e.nib !== nibble) begin
                     errors++;
                     $display("FAIL slot digit_en=%b nibble=%h required digit_en=%b nibble=%h",
                              digit_en, nibble, e.en, e.nib);
                  end
               end
            end
            if (digit_en != 4'b0) begin
               run++;
            end else if (run != 0) begin
               if (len_chk) begin
                  checks++;
                  if (run != 6) begin
                     errors++;
                     $display("FAIL lit_run_length actual=%0d required=6", run);
                  end
               end
               run = 0;
            end
            if (frame_tick) begin
               checks++;
               if (gap != exp_gap) begin
                  errors++;
                  $display("FAIL frame_tick_gap actual=%0d required=%0d", gap, exp_gap);
               end
               gap = 0;
            end
            prev_en = digit_en;
         end
      end
   end

   // Stimulus
   initial begin : stimulus
      rst_n       = 1'b1;
      en          = 1'b1;
      value_valid = 1'b0;
      value       = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_digit_en", 32'(digit_en), 32'd0);
      chk("reset_nibble", 32'(nibble), 32'd0);
      chk("reset_frame_tick", 32'(frame_tick), 32'd0);
      chk("reset_value_ready", 32'(value_ready), 32'd1);
      push_frame(16'h0000, LIT_ZERO);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Free-running scan of an empty display
      wait_tick();
      push_frame(16'h0000, LIT_ZERO);

      // Load mid-frame; old value holds until the wrap
      step(5);
      value       = 16'h12A4;
      value_valid = 1'b1;
      step(1);
      value_valid = 1'b0;
      chk("ready_after_accept", 32'(value_ready), 32'd0);
      step(10);
      chk("ready_while_pending", 32'(value_ready), 32'd0);
      wait_tick();
      push_frame(16'h12A4, 4'b1111);
      chk("ready_at_apply", 32'(value_ready), 32'd0);
      step(1);
      chk("ready_after_apply", 32'(value_ready), 32'd1);

      // Back-to-back offers: only the first is taken until the apply
      value       = 16'h5555;
      value_valid = 1'b1;
      step(1);
      value = 16'h6666;
      chk("ready_after_5555", 32'(value_ready), 32'd0);
      wait_tick();
      push_frame(16'h5555, 4'b1111);
      chk("ready_6666_waiting", 32'(value_ready), 32'd0);
      step(1);
      chk("ready_for_6666", 32'(value_ready), 32'd1);
      step(1);
      value_valid = 1'b0;
      chk("ready_after_6666", 32'(value_ready), 32'd0);
      wait_tick();
      push_frame(16'h6666, 4'b1111);

      // Pause scanning for 20 cycles in the middle of digit 2's slot
      wait_tick();
      push_ev(4'b0001, 4'h6);
      push_ev(4'b0010, 4'h6);
      push_ev(4'b0100, 4'h6);
      push_ev(4'b0100, 4'h6);
      push_ev(4'b1000, 4'h6);
      exp_gap = 52;
      len_chk = 1'b0;
      step(20);
      chk("digit2_lit_before_pause", 32'(digit_en), 32'h4);
      en = 1'b0;
      step(1);
      chk("pause_digit_en", 32'(digit_en), 32'd0);
      step(5);
      chk("pause_digit_en_held", 32'(digit_en), 32'd0);
      chk("pause_frame_tick", 32'(frame_tick), 32'd0);
      chk("pause_nibble", 32'(nibble), 32'h6);
      step(14);
      en = 1'b1;
      step(1);
      chk("resume_digit2", 32'(digit_en), 32'h4);

      // Reset mid-slot with a pending value
      wait_tick();
      exp_gap = 32;
      push_ev(4'b0001, 4'h6);
      push_ev(4'b0010, 4'h6);
      value       = 16'h9876;
      value_valid = 1'b1;
      step(1);
      value_valid = 1'b0;
      chk("ready_pending_9876", 32'(value_ready), 32'd0);
      step(11);
      rst_n = 1'b0;
      #1;
      chk("async_reset_digit_en", 32'(digit_en), 32'd0);
      chk("async_reset_nibble", 32'(nibble), 32'd0);
      chk("async_reset_frame_tick", 32'(frame_tick), 32'd0);
      chk("async_reset_ready", 32'(value_ready), 32'd1);
      chk("events_before_reset", exp_q.size(), 32'd0);
      exp_q.delete();
      @(negedge clk);
      #1;
      push_frame(16'h0000, LIT_ZERO);
      len_chk = 1'b1;
      rst_n   = 1'b1;
      wait_tick();
      push_frame(16'h0000, LIT_ZERO);

      // Leading-zero patterns
      step(3);
      value       = 16'h00A0;
      value_valid = 1'b1;
      step(1);
      value_valid = 1'b0;
      wait_tick();
      push_frame(16'h00A0, LIT_00A0);
      step(1);
      value       = 16'h0000;
      value_valid = 1'b1;
      step(1);
      value_valid = 1'b0;
      wait_tick();
      push_frame(16'h0000, LIT_ZERO);
      wait_tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
